// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_arbiter
// Brief    : NR-input round-robin arbiter with one registered output slot,
//            publishing the winner as one-hot grant plus binary index.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter #(
    parameter  int NR = 4,
    parameter  int DW = 32,
    localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    in_valid,
    output logic [NR-1:0]    in_ready,
    input  logic [NR*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [NR-1:0]    out_grant,
    output logic [IW-1:0]    out_idx
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic          w_load_en;
    logic          w_found;
    logic [IW-1:0] w_win;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [NR-1:0] w_onehot;
    logic [DW-1:0] w_sel_data;
    logic [DW-1:0] r_data;
    logic [NR-1:0] r_grant;
    logic [IW-1:0] r_idx;

    // ------------------------------------------------------------------
    // Slot FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_found ? S_FULL : S_EMPTY;
        end
    end

    // The slot may refill in the same cycle it drains.
    always_comb begin
        out_valid = (r_state == S_FULL);
        w_load_en = !out_valid || out_ready;
    end

    // ------------------------------------------------------------------
    // Winner search: first valid requester starting at the pointer, wrapping
    // ------------------------------------------------------------------
    always_comb begin : p_scan
        int w_j;
        w_found = 1'b0;
        w_win   = '0;
        w_j     = 0;
        for (int k = 0; k < NR; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NR) begin
                w_j = w_j - NR;
            end
            if (!w_found && in_valid[w_j]) begin
                w_found = 1'b1;
                w_win   = IW'(w_j);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_win == IW'(gi));
        end
    endgenerate

    always_comb begin
        w_sel_data = in_data[int'(w_win)*DW +: DW];
    end

    // Only one bit can be set since w_onehot is a decoded single index.
    always_comb begin
        in_ready = '0;
        if (!rst && w_load_en && w_found) begin
            in_ready = w_onehot;
        end
    end

    generate
        if (NR == 1) begin : g_ptr_fixed
            assign w_ptr_nxt = '0;
        end else begin : g_ptr_rr
            assign w_ptr_nxt = (int'(w_win) == NR - 1) ? '0 : IW'(int'(w_win) + 1);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: content and pointer only move on an actual grant, so an
    // idle refill leaves the last item's fields visible.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (w_load_en && w_found) begin
            r_data  <= w_sel_data;
            r_grant <= w_onehot;
            r_idx   <= w_win;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign out_data  = r_data;
    assign out_grant = r_grant;
    assign out_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_rr_arbiter
// Brief    : Directed scoreboard bench for onehot_rr_arbiter (NR=4, DW=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [NR-1:0] g;
        logic [IW-1:0] i;
    } item_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    in_valid = '1;
    logic [NR-1:0]    in_ready;
    logic [NR*DW-1:0] in_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    out_data;
    logic [NR-1:0]    out_grant;
    logic [IW-1:0]    out_idx;

    item_t sbq[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    onehot_rr_arbiter #(.NR(NR), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_grant (out_grant),
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; w is the hand-computed winner (-1 = no grant expected).
    task automatic step(input logic [NR-1:0] v, input logic ordy, input int w);
        logic [NR-1:0] exp_rdy;
        item_t it;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = v;
        out_ready = ordy;
        #1;
        exp_rdy = (w >= 0) ? NR'(1 << w) : '0;
        check("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
        if (w >= 0) begin
            it.d = 32'hA0 + w;
            it.g = exp_rdy;
            it.i = IW'(w);
            sbq.push_back(it);
        end
    endtask

    // Item held in the slot is discarded by reset, so pending expectations go too.
    task automatic do_reset(input logic ordy);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = ordy;
        #1;
        check("in_ready_in_rst", {60'd0, in_ready}, 64'd0);
        sbq.delete();
        @(posedge clk);
        #2;
        check("in_ready_in_rst", {60'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    // Monitor: every downstream handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_item", 64'd1, 64'd0);
            end else begin
                item_t e;
                e = sbq.pop_front();
                check("out_data",  {32'd0, out_data},  {32'd0, e.d});
                check("out_grant", {60'd0, out_grant}, {60'd0, e.g});
                check("out_idx",   {62'd0, out_idx},   {62'd0, e.i});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            in_data[i*DW +: DW] = 32'hA0 + i;
        end

        // Reset with all requesters valid
        @(posedge clk);
        #2;
        check("in_ready_in_rst", {60'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  {32'd0, out_data}, 64'd0);
        check("rst_out_grant", {60'd0, out_grant}, 64'd0);
        check("rst_out_idx",   {62'd0, out_idx}, 64'd0);

        // All valid, streaming: 0,1,2,3,0
        step(4'b1111, 1'b1, 0);
        step(4'b1111, 1'b1, 1);
        step(4'b1111, 1'b1, 2);
        step(4'b1111, 1'b1, 3);
        step(4'b1111, 1'b1, 0);
        step(4'b0000, 1'b1, -1);

        // Sparse requests from ptr=0: 1,3,1
        do_reset(1'b1);
        step(4'b1010, 1'b1, 1);
        step(4'b1010, 1'b1, 3);
        step(4'b1010, 1'b1, 1);

        // Backpressure for 5 cycles with A1 in the slot
        for (int c = 0; c < 5; c++) begin
            step(4'b1010, 1'b0, -1);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_data",  {32'd0, out_data}, 64'hA1);
            check("bp_out_grant", {60'd0, out_grant}, 64'b0010);
        end
        step(4'b1010, 1'b1, 3);
        step(4'b0000, 1'b1, -1);

        // Single requester 2, then idle; ptr moves to 3
        step(4'b0100, 1'b1, 2);
        step(4'b0000, 1'b1, -1);
        step(4'b0000, 1'b1, -1);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_hold_data", {32'd0, out_data}, 64'hA2);
        check("idle_hold_idx",  {62'd0, out_idx}, 64'd2);
        step(4'b1001, 1'b1, 3);
        step(4'b1001, 1'b1, 0);
        step(4'b0000, 1'b1, -1);

        // Reset while FULL under backpressure; next round restarts at 0
        step(4'b1111, 1'b0, 1);
        step(4'b1111, 1'b0, -1);
        check("full_before_rst", {63'd0, out_valid}, 64'd1);
        do_reset(1'b0);
        step(4'b1111, 1'b1, 0);
        step(4'b1111, 1'b1, 1);
        step(4'b1111, 1'b1, 2);
        step(4'b1111, 1'b1, 3);
        step(4'b0000, 1'b1, -1);
        step(4'b0000, 1'b1, -1);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
